// File: rtl/polaris_mem_pkg.sv
// rtl/polaris_mem_pkg.sv - shared size encodings, stage state and legal-size helper for the memory stage
package polaris_mem_pkg;

  localparam logic [3:0] SZ_NONE = 4'd0;
  localparam logic [3:0] SZ_B    = 4'd1;
  localparam logic [3:0] SZ_H    = 4'd2;
  localparam logic [3:0] SZ_W    = 4'd4;
  localparam logic [3:0] SZ_D    = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Doubleword accesses only exist on a 64-bit bus; multi-hot codes are never legal.
  function automatic logic is_legal_size(input logic [3:0] cyc, input int xlen);
    return (cyc == SZ_B) || (cyc == SZ_H) || (cyc == SZ_W) || ((cyc == SZ_D) && (xlen == 64));
  endfunction

endpackage

// File: rtl/m_lane_steer.sv
// rtl/m_lane_steer.sv - byte-lane steering: store data/select placement and load extraction with extension
module m_lane_steer
  import polaris_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [$clog2(XLEN/8)-1:0] st_lane,
  input  logic [3:0]                st_size,
  input  logic [XLEN-1:0]           wrdata,
  output logic [XLEN/8-1:0]         sel,
  output logic [XLEN-1:0]           dat_o,
  input  logic [XLEN-1:0]           dat_i,
  input  logic [$clog2(XLEN/8)-1:0] ld_lane,
  input  logic [3:0]                ld_size,
  input  logic                      is_unsigned,
  output logic [XLEN-1:0]           result
);

  logic [XLEN/8:0]          run;
  logic [XLEN-1:0]          ext;
  logic [6:0]               nbits;
  logic [$clog2(XLEN)-1:0]  top;
  logic                     fill;

  always_comb begin
    run   = ((XLEN/8+1)'(1) << st_size) - (XLEN/8+1)'(1);
    sel   = run[XLEN/8-1:0] << st_lane;
    dat_o = wrdata << {st_lane, 3'b000};

    // A full-width access has nbits == XLEN, so every bit comes from ext and nothing is extended.
    ext   = dat_i >> {ld_lane, 3'b000};
    nbits = {ld_size, 3'b000};
    top   = $clog2(XLEN)'(nbits - 7'd1);
    fill  = ~is_unsigned & ext[top] & (ld_size != SZ_NONE);
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (7'(i) < nbits) ? ext[i] : fill;
    end
  end

endmodule

// File: rtl/stage_m_wb.sv
// rtl/stage_m_wb.sv - memory stage: X request to registered Wishbone cycle, W result; STAGE_M_WB_MISALIGN_TRAP_EN enables the misalignment trap
module stage_m_wb
  import polaris_mem_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        m_cyc_i,
  input  logic [AW-1:0]     m_alu_i,
  input  logic [XLEN-1:0]   m_wrdata_i,
  input  logic              m_store_i,
  input  logic              m_unsigned_i,
  input  logic [4:0]        m_destination_i,
  output logic              m_stall_o,
  output logic [XLEN-1:0]   m_result_o,
  output logic [4:0]        m_destination_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [XLEN/8-1:0] wb_sel_o,
  output logic [XLEN-1:0]   wb_dat_o,
  input  logic [XLEN-1:0]   wb_dat_i,
  input  logic              wb_ack_i,
  output logic              m_misalign_o
);

  localparam int LANES = XLEN / 8;
  localparam int LW    = $clog2(LANES);

  state_t            state;
  logic [3:0]        size_x, size_q;
  logic [LW-1:0]     lane_x, lane_q;
  logic              unsigned_q;
  logic [AW-1:0]     alu_q;
  logic [LANES-1:0]  sel_x;
  logic [XLEN-1:0]   dat_x, ld_result;
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
  logic              mis_x;
`endif

  // size_x is the effective access size: SZ_NONE whenever no bus cycle will be issued.
  always_comb begin
    size_x = is_legal_size(m_cyc_i, XLEN) ? m_cyc_i : SZ_NONE;
    lane_x = m_alu_i[LW-1:0];
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
    mis_x  = (size_x != SZ_NONE) && ((lane_x & LW'(size_x - 4'd1)) != '0);
    if (mis_x) size_x = SZ_NONE;
`else
    lane_x = m_alu_i[LW-1:0] & ~LW'(size_x - 4'd1);
`endif
  end

  m_lane_steer #(.XLEN(XLEN)) u_steer (
    .st_lane     (lane_x),
    .st_size     (size_x),
    .wrdata      (m_wrdata_i),
    .sel         (sel_x),
    .dat_o       (dat_x),
    .dat_i       (wb_dat_i),
    .ld_lane     (lane_q),
    .ld_size     (size_q),
    .is_unsigned (unsigned_q),
    .result      (ld_result)
  );

  assign m_stall_o = (state == BUSY) & ~wb_ack_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= IDLE;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
      wb_we_o         <= 1'b0;
      wb_sel_o        <= '0;
      wb_dat_o        <= '0;
      wb_adr_o        <= '0;
      m_destination_o <= '0;
      size_q          <= SZ_NONE;
      lane_q          <= '0;
      alu_q           <= '0;
      unsigned_q      <= 1'b0;
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
      m_misalign_o    <= 1'b0;
`endif
    end else if (!m_stall_o) begin
      state           <= (size_x != SZ_NONE) ? BUSY : IDLE;
      wb_cyc_o        <= (size_x != SZ_NONE);
      wb_stb_o        <= (size_x != SZ_NONE);
      wb_we_o         <= (size_x != SZ_NONE) && m_store_i;
      wb_sel_o        <= sel_x;
      wb_dat_o        <= dat_x;
      wb_adr_o        <= {m_alu_i[AW-1:LW], {LW{1'b0}}};
      m_destination_o <= m_destination_i;
      size_q          <= size_x;
      lane_q          <= lane_x;
      alu_q           <= m_alu_i;
      unsigned_q      <= m_unsigned_i;
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
      m_misalign_o    <= mis_x;
`endif
    end
  end

`ifndef STAGE_M_WB_MISALIGN_TRAP_EN
  assign m_misalign_o = 1'b0;
`endif

  always_comb begin
    m_result_o = (size_q == SZ_NONE) ? XLEN'(alu_q) : ld_result;
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
    if (m_misalign_o) m_result_o = '0;
`endif
  end

endmodule

// File: tb/tb_stage_m_wb.sv
// tb/tb_stage_m_wb.sv - directed and randomized checks of stage_m_wb against a behavioural model
module tb_stage_m_wb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  m_cyc_i;
  logic [63:0] m_alu_i, m_wrdata_i, m_result_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic        m_store_i, m_unsigned_i, m_stall_o;
  logic [4:0]  m_destination_i, m_destination_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, m_misalign_o;
  logic [7:0]  wb_sel_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_m_wb #(.XLEN(64), .AW(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .m_cyc_i(m_cyc_i), .m_alu_i(m_alu_i),
    .m_wrdata_i(m_wrdata_i), .m_store_i(m_store_i), .m_unsigned_i(m_unsigned_i),
    .m_destination_i(m_destination_i), .m_stall_o(m_stall_o), .m_result_o(m_result_o),
    .m_destination_o(m_destination_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .m_misalign_o(m_misalign_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte count n, aligned lane, select run, shifted data, extended load value.
  function automatic void model(input logic [3:0] cyc, input logic [63:0] alu, wd, di,
                                input logic uns, output logic go, output logic mis,
                                output logic [63:0] sel, adr, dat, res);
    int n, lane;
    logic [63:0] ext, mask;
    n    = (cyc == 4'd1 || cyc == 4'd2 || cyc == 4'd4 || cyc == 4'd8) ? int'(cyc) : 0;
    lane = int'(alu % 64'd8);
    mis  = 1'b0;
    if (n != 0 && (lane % n) != 0) begin
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
      mis = 1'b1;
      n   = 0;
`else
      lane = lane - (lane % n);
`endif
    end
    go  = (n != 0);
    sel = ((64'd1 << n) - 64'd1) << lane;
    adr = alu & ~64'd7;
    dat = wd << (8 * lane);
    ext = di >> (8 * lane);
    if (mis) res = 64'd0;
    else if (n == 0) res = alu;
    else if (n == 8) res = ext;
    else begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      res  = ext & mask;
      if (!uns && res[8*n-1]) res = res | ~mask;
    end
  endfunction

  // Called between edges; leaves ack high after a bus cycle so the next call can run back-to-back.
  task automatic xact(input logic [3:0] cyc, input logic [63:0] alu, wd, di,
                      input logic st, uns, input logic [4:0] dst, input int waits);
    logic go, mis;
    logic [63:0] e_sel, e_adr, e_dat, e_res;
    model(cyc, alu, wd, di, uns, go, mis, e_sel, e_adr, e_dat, e_res);
    m_cyc_i = cyc; m_alu_i = alu; m_wrdata_i = wd; m_store_i = st;
    m_unsigned_i = uns; m_destination_i = dst;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    wb_dat_i = {$urandom, $urandom};
    m_cyc_i = 4'd0; m_alu_i = ~alu; m_destination_i = ~dst;
    #1;
    chk("cyc", wb_cyc_o, go);
    chk("stb", wb_stb_o, go);
    chk("dest", m_destination_o, dst);
    chk("misalign", m_misalign_o, mis);
    if (go) begin
      chk("we", wb_we_o, st);
      chk("sel", wb_sel_o, e_sel);
      chk("adr", wb_adr_o, e_adr);
      if (st) chk("dat", wb_dat_o, e_dat);
      for (int w = 0; w < waits; w++) begin
        chk("stall_wait", m_stall_o, 1);
        m_cyc_i = 4'($urandom); m_alu_i = {$urandom, $urandom}; m_destination_i = 5'd31;
        @(posedge clk); #1;
        chk("cyc_hold", wb_cyc_o, 1);
        chk("adr_hold", wb_adr_o, e_adr);
        chk("dest_hold", m_destination_o, dst);
      end
      m_cyc_i = 4'd0;
      wb_dat_i = di; wb_ack_i = 1'b1;
      #1;
      chk("stall_ack", m_stall_o, 0);
      if (!st) chk("result", m_result_o, e_res);
    end else begin
      chk("stall_idle", m_stall_o, 0);
      chk("result_nobus", m_result_o, e_res);
    end
  endtask

  initial begin
    logic [3:0] rc;
    reset_i = 1'b1; m_cyc_i = 4'd8; wb_ack_i = 1'b1; m_alu_i = 64'h1234_5678_9abc_def1;
    m_wrdata_i = '1; m_store_i = 1'b1; m_unsigned_i = 1'b0; m_destination_i = 5'd9;
    wb_dat_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_sel", wb_sel_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_dest", m_destination_o, 0);
    chk("rst_mis", m_misalign_o, 0);
    chk("rst_stall", m_stall_o, 0);
    m_cyc_i = 4'd0; reset_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cyc", wb_cyc_o, 0);
    chk("post_rst_stall", m_stall_o, 0);

    xact(4'd1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 5'd3, 1);
    chk("tp_lb_sel", wb_sel_o, 64'h08);
    chk("tp_lb_adr", wb_adr_o, 64'h1000);
    chk("tp_lb_res", m_result_o, 64'hFFFF_FFFF_FFFF_FF80);
    xact(4'd1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 5'd4, 0);
    chk("tp_lbu_res", m_result_o, 64'h80);

    xact(4'd4, 64'h2004, 64'h0011_2233_4455_6677, 64'd0, 1'b1, 1'b0, 5'd7, 0);
    chk("tp_sw_we", wb_we_o, 1);
    chk("tp_sw_sel", wb_sel_o, 64'hF0);
    chk("tp_sw_dat", wb_dat_o, 64'h4455_6677_0000_0000);

    xact(4'd8, 64'h3000, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 5'd14, 3);
    chk("tp_wait_dest", m_destination_o, 14);
    chk("tp_wait_res", m_result_o, 64'hDEAD_BEEF_0BAD_F00D);

    xact(4'd0, 64'h1122_3344_5566_7788, 64'd0, 64'd0, 1'b0, 1'b0, 5'd1, 0);
    m_alu_i = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = ~wb_ack_i;
      @(posedge clk); #1;
      chk("sz0_stall", m_stall_o, 0);
      chk("sz0_cyc", wb_cyc_o, 0);
      chk("sz0_res", m_result_o, 64'h1122_3344_5566_7788);
    end

    xact(4'd2, 64'h1001, 64'h0000_0000_0000_BEEF, 64'h0, 1'b1, 1'b0, 5'd2, 0);
`ifdef STAGE_M_WB_MISALIGN_TRAP_EN
    chk("tp_mis_cyc", wb_cyc_o, 0);
    chk("tp_mis_flag", m_misalign_o, 1);
    @(posedge clk); #1;
    chk("tp_mis_pulse", m_misalign_o, 0);
`else
    chk("tp_mal_sel", wb_sel_o, 64'h03);
    chk("tp_mal_adr", wb_adr_o, 64'h1000);
`endif

    xact(4'd3, 64'h4000, 64'd0, 64'd0, 1'b0, 1'b0, 5'd5, 0);
    chk("illegal_cyc", wb_cyc_o, 0);

    m_cyc_i = 4'd4; m_alu_i = 64'h5000; m_store_i = 1'b0;
    @(posedge clk); #1;
    wb_ack_i = 1'b0; m_cyc_i = 4'd0;
    #1;
    chk("mid_busy", m_stall_o, 1);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_stall", m_stall_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: rc = 4'd1;
        1: rc = 4'd2;
        2: rc = 4'd4;
        3: rc = 4'd8;
        4: rc = 4'd0;
        default: rc = 4'($urandom);
      endcase
      xact(rc, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
           1'($urandom), 1'($urandom), 5'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
